hamming_pipe: RTL and testbench



---
 rtl/hamming_pipe_pkg.sv | 31 +++
 rtl/hamming_pipe_tree.sv | 71 +++++++
 rtl/hamming_pipe.sv | 66 ++++++
 tb/tb_hamming_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pipe_pkg.sv
// Shared width and stage-count helpers for the hamming_pipe popcount pipeline.
package hamming_pipe_pkg;

  // Smallest r with 2**r >= n; used for OBIT (n = NBITS+1) and tree depth LV (n = NBITS).
  function automatic int clog2w(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int tree_reg_stages(input int lv, input int reg_every);
    return (lv + reg_every - 1) / reg_every;
  endfunction

  // Total registers from acceptance to o_valid: input stage plus tree stages.
  function automatic int pipe_stages(input int nbits, input int reg_every);
    return 1 + tree_reg_stages(clog2w(nbits), reg_every);
  endfunction

  // Operand count at tree level k (level 0 = the raw bits).
  function automatic int level_count(input int nbits, input int k);
    return (nbits + (1 << k) - 1) >> k;
  endfunction

endpackage

// File: rtl/hamming_pipe_tree.sv
// Single-channel popcount: input register, then a binary adder tree that is
// registered every REG_EVERY levels and after its last level.
module hamming_pipe_tree
  import hamming_pipe_pkg::*;
#(
  parameter int NBITS     = 24,
  parameter int REG_EVERY = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rstn,
  input  logic                            i_adv,
  input  logic [NBITS-1:0]                i_vec,
  output logic [clog2w(NBITS+1)-1:0]      o_cost
);

  localparam int OBIT = clog2w(NBITS + 1);
  localparam int LV   = clog2w(NBITS);

  logic [NBITS-1:0] vec_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vec_q <= '0;
    end else if (i_adv) begin
      vec_q <= i_vec;
    end
  end

  // Partial sums at level k fit in k+1 bits; the upper bits of each OBIT-wide
  // node are constant zero and fold away.
  for (genvar k = 0; k <= LV; k++) begin : g_lvl
    localparam int NK = level_count(NBITS, k);
    logic [OBIT-1:0] lvl_node [NK];

    if (k == 0) begin : g_leaf
      for (genvar i = 0; i < NK; i++) begin : g_bit
        assign lvl_node[i] = OBIT'(vec_q[i]);
      end
    end else begin : g_sum
      localparam int NP     = level_count(NBITS, k - 1);
      localparam bit IS_REG = ((k % REG_EVERY) == 0) || (k == LV);

      for (genvar j = 0; j < NK; j++) begin : g_node
        logic [OBIT-1:0] sum_d;

        if (2 * j + 1 < NP) begin : g_add
          assign sum_d = g_lvl[k-1].lvl_node[2*j] + g_lvl[k-1].lvl_node[2*j+1];
        end else begin : g_pass
          assign sum_d = g_lvl[k-1].lvl_node[2*j];
        end

        if (IS_REG) begin : g_reg
          logic [OBIT-1:0] sum_q;
          always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
              sum_q <= '0;
            end else if (i_adv) begin
              sum_q <= sum_d;
            end
          end
          assign lvl_node[j] = sum_q;
        end else begin : g_comb
          assign lvl_node[j] = sum_d;
        end
      end
    end
  end

  assign o_cost = g_lvl[LV].lvl_node[0];

endmodule

// File: rtl/hamming_pipe.sv
// Multi-channel Hamming-distance / popcount pipeline with a stall-able
// valid shift register alongside NCH independent adder trees.
module hamming_pipe
  import hamming_pipe_pkg::*;
#(
  parameter int NBITS     = 24,
  parameter int NCH       = 4,
  parameter int REG_EVERY = 1,
  parameter int XOR_EN    = 1
) (
  input  logic                                i_clk,
  input  logic                                i_rstn,
  input  logic [NBITS-1:0]                    i_ref,
  input  logic [NCH*NBITS-1:0]                i_cand,
  input  logic                                i_valid,
  output logic                                o_ready,
  output logic [NCH*clog2w(NBITS+1)-1:0]      o_cost,
  output logic                                o_valid,
  input  logic                                i_ready
);

  localparam int OBIT = clog2w(NBITS + 1);
  localparam int NSTG = pipe_stages(NBITS, REG_EVERY);

  // Handshake: a beat moves on a clock edge only when valid and ready are both
  // high; the whole pipe advances together whenever the output slot is free
  // or being consumed, so o_ready is exactly that advance enable.
  logic            adv;
  logic [NSTG-1:0] vld_q;
  logic [NSTG-1:0] vld_d;

  assign adv     = i_ready || !o_valid;
  assign o_ready = adv;
  assign o_valid = vld_q[NSTG-1];
  assign vld_d   = {vld_q[NSTG-2:0], i_valid};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [NBITS-1:0] vec;

    if (XOR_EN != 0) begin : g_xor
      assign vec = i_ref ^ i_cand[c*NBITS +: NBITS];
    end else begin : g_raw
      assign vec = i_cand[c*NBITS +: NBITS];
    end

    hamming_pipe_tree #(
      .NBITS     (NBITS),
      .REG_EVERY (REG_EVERY)
    ) u_tree (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_adv  (adv),
      .i_vec  (vec),
      .o_cost (o_cost[c*OBIT +: OBIT])
    );
  end

endmodule

// File: tb/tb_hamming_pipe.sv
// Bench for hamming_pipe: default config plus an odd-width/no-XOR config and a
// minimal 2-bit config, checked against a $countones reference model.
module tb_hamming_pipe;

  localparam int L0 = 6;
  localparam int L1 = 4;
  localparam int L2 = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // u0: defaults (NBITS=24, NCH=4, REG_EVERY=1, XOR_EN=1), OBIT=5
  logic [23:0] ref0;
  logic [95:0] cand0;
  logic        valid0, ready0, ovalid0, iready0;
  logic [19:0] cost0;

  // u1: NBITS=25, NCH=2, REG_EVERY=2, XOR_EN=0, OBIT=5
  logic [24:0] ref1;
  logic [49:0] cand1;
  logic        valid1, ready1, ovalid1, iready1;
  logic [9:0]  cost1;

  // u2: NBITS=2, NCH=1, OBIT=2
  logic [1:0]  ref2, cand2;
  logic        valid2, ready2, ovalid2, iready2;
  logic [1:0]  cost2;

  hamming_pipe u0 (
    .i_clk(clk), .i_rstn(rstn), .i_ref(ref0), .i_cand(cand0), .i_valid(valid0),
    .o_ready(ready0), .o_cost(cost0), .o_valid(ovalid0), .i_ready(iready0)
  );

  hamming_pipe #(.NBITS(25), .NCH(2), .REG_EVERY(2), .XOR_EN(0)) u1 (
    .i_clk(clk), .i_rstn(rstn), .i_ref(ref1), .i_cand(cand1), .i_valid(valid1),
    .o_ready(ready1), .o_cost(cost1), .o_valid(ovalid1), .i_ready(iready1)
  );

  hamming_pipe #(.NBITS(2), .NCH(1)) u2 (
    .i_clk(clk), .i_rstn(rstn), .i_ref(ref2), .i_cand(cand2), .i_valid(valid2),
    .o_ready(ready2), .o_cost(cost2), .o_valid(ovalid2), .i_ready(iready2)
  );

  int checks   = 0;
  int failures = 0;
  logic [19:0] exp_q[$];

  function automatic logic [19:0] model0(input logic [23:0] r, input logic [95:0] c);
    logic [19:0] res;
    res = '0;
    for (int ch = 0; ch < 4; ch++) res[ch*5 +: 5] = 5'($countones(r ^ c[ch*24 +: 24]));
    return res;
  endfunction

  function automatic logic [9:0] model1(input logic [49:0] c);
    logic [9:0] res;
    res = '0;
    for (int ch = 0; ch < 2; ch++) res[ch*5 +: 5] = 5'($countones(c[ch*25 +: 25]));
    return res;
  endfunction

  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Drivers: present one beat on an idle pipe, return cycles until o_valid.
  task automatic send_one0(input logic [23:0] r, input logic [95:0] c, output int lat);
    @(posedge clk); #1;
    iready0 = 1'b1; ref0 = r; cand0 = c; valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (ovalid0) break;
    end
  endtask

  task automatic send_one1(input logic [24:0] r, input logic [49:0] c, output int lat);
    @(posedge clk); #1;
    iready1 = 1'b1; ref1 = r; cand1 = c; valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (ovalid1) break;
    end
  endtask

  task automatic test_reset;
    int stale;
    rstn = 1'b0;
    ref0 = '0; cand0 = '0; valid0 = 1'b0; iready0 = 1'b1;
    ref1 = '0; cand1 = '0; valid1 = 1'b0; iready1 = 1'b1;
    ref2 = '0; cand2 = '0; valid2 = 1'b0; iready2 = 1'b1;
    #2;
    valid0 = 1'b1; cand0 = rand96();
    repeat (3) @(negedge clk);
    checks++;
    if (ovalid0 !== 1'b0) begin failures++; $display("FAIL reset_ovalid got=%b exp=0", ovalid0); end
    checks++;
    if (cost0 !== 20'd0) begin failures++; $display("FAIL reset_cost got=%h exp=0", cost0); end
    checks++;
    if (ready0 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready0); end
    checks++;
    if (ovalid1 !== 1'b0 || ovalid2 !== 1'b0 || cost1 !== 10'd0 || cost2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_others ov1=%b ov2=%b c1=%h c2=%h exp all 0", ovalid1, ovalid2, cost1, cost2);
    end
    @(posedge clk); #1;
    valid0 = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (ovalid0) stale++;
    end
    checks++;
    if (stale !== 0) begin failures++; $display("FAIL reset_accept outputs=%0d exp=0", stale); end
  endtask

  task automatic test_basic;
    int lat;
    logic [19:0] exp;
    exp = {5'd12, 5'd1, 5'd24, 5'd0};
    send_one0(24'h0, {24'hAAAAAA, 24'h000001, 24'hFFFFFF, 24'h000000}, lat);
    checks++;
    if (lat !== L0) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, L0); end
    checks++;
    if (cost0 !== exp) begin failures++; $display("FAIL basic_cost got=%h exp=%h", cost0, exp); end
  endtask

  task automatic test_stream(input int n, input bit stall, input bit gaps, input string name);
    int sent, got, cyc;
    bit acc, hold_prev;
    logic [19:0] prev_cost, exp;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0; hold_prev = 0; prev_cost = '0;
    @(posedge clk); #1;
    iready0 = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    ref0 = 24'($urandom); cand0 = rand96(); valid0 = 1'b1;
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      if (hold_prev) begin
        checks++;
        if (ovalid0 !== 1'b1 || cost0 !== prev_cost) begin
          failures++;
          $display("FAIL %s_hold ovalid=%b cost=%h exp valid=1 cost=%h", name, ovalid0, cost0, prev_cost);
        end
      end
      hold_prev = ovalid0 && !iready0;
      prev_cost = cost0;
      if (ovalid0 && iready0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s_extra got=%h exp=no output", name, cost0);
        end else begin
          exp = exp_q.pop_front();
          if (cost0 !== exp) begin
            failures++;
            $display("FAIL %s_data idx=%0d got=%h exp=%h", name, got, cost0, exp);
          end
        end
        got++;
      end
      acc = valid0 && ready0;
      if (acc) begin
        exp_q.push_back(model0(ref0, cand0));
        sent++;
      end
      @(posedge clk); #1;
      if (acc || !valid0) begin
        if (sent < n && (!gaps || $urandom_range(0, 1) == 1)) begin
          valid0 = 1'b1; ref0 = 24'($urandom); cand0 = rand96();
        end else begin
          valid0 = 1'b0;
        end
      end
      iready0 = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    valid0 = 1'b0;
    iready0 = 1'b1;
    checks++;
    if (got !== n || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL %s_count got=%0d pending=%0d exp=%0d pending=0", name, got, exp_q.size(), n);
    end
    if (!stall && !gaps) begin
      checks++;
      if (cyc !== n + L0) begin
        failures++;
        $display("FAIL %s_rate cycles=%0d exp=%0d", name, cyc, n + L0);
      end
    end
  endtask

  task automatic test_reset_flight;
    int lat, stale;
    logic [23:0] r;
    logic [95:0] c;
    iready0 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      valid0 = 1'b1; ref0 = 24'($urandom); cand0 = rand96();
    end
    @(posedge clk); #1;
    valid0 = 1'b0;
    checks++;
    if (ovalid0 !== 1'b1) begin failures++; $display("FAIL flight_pre ovalid=%b exp=1", ovalid0); end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (ovalid0 !== 1'b0 || cost0 !== 20'd0) begin
      failures++;
      $display("FAIL flight_async ovalid=%b cost=%h exp 0/0", ovalid0, cost0);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (ovalid0) stale++;
    end
    checks++;
    if (stale !== 0) begin failures++; $display("FAIL flight_stale outputs=%0d exp=0", stale); end
    r = 24'($urandom);
    c = rand96();
    send_one0(r, c, lat);
    checks++;
    if (lat !== L0) begin failures++; $display("FAIL flight_latency got=%0d exp=%0d", lat, L0); end
    checks++;
    if (cost0 !== model0(r, c)) begin
      failures++;
      $display("FAIL flight_cost got=%h exp=%h", cost0, model0(r, c));
    end
  endtask

  task automatic test_odd_width;
    int lat;
    logic [49:0] c;
    logic [24:0] r;
    for (int i = 0; i < 6; i++) begin
      r = 25'($urandom);
      c = (i == 0) ? {50{1'b1}} : {18'($urandom), $urandom};
      send_one1(r, c, lat);
      checks++;
      if (lat !== L1) begin failures++; $display("FAIL odd_latency beat=%0d got=%0d exp=%0d", i, lat, L1); end
      checks++;
      if (cost1 !== model1(c)) begin
        failures++;
        $display("FAIL odd_cost beat=%0d got=%h exp=%h", i, cost1, model1(c));
      end
    end
  endtask

  task automatic test_tiny;
    logic [1:0] beats [4];
    logic [1:0] expc  [4];
    bit exp_v;
    beats = '{2'b00, 2'b01, 2'b11, 2'b10};
    expc  = '{2'd0, 2'd1, 2'd2, 2'd1};
    @(posedge clk); #1;
    iready2 = 1'b1; ref2 = 2'b00; cand2 = beats[0]; valid2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_v = (i >= L2) && (i < L2 + 4);
      checks++;
      if (ovalid2 !== exp_v) begin
        failures++;
        $display("FAIL tiny_valid cycle=%0d got=%b exp=%b", i, ovalid2, exp_v);
      end else if (exp_v) begin
        checks++;
        if (cost2 !== expc[i-L2]) begin
          failures++;
          $display("FAIL tiny_cost cycle=%0d got=%0d exp=%0d", i, cost2, expc[i-L2]);
        end
      end
      @(posedge clk); #1;
      if (i + 1 < 4) cand2 = beats[i+1];
      else valid2 = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stream(100, 1'b0, 1'b0, "stream");
    test_stream(100, 1'b1, 1'b0, "stall");
    test_stream(60, 1'b1, 1'b1, "bubble");
    test_reset_flight();
    test_odd_width();
    test_tiny();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
